// File: rtl/tx_mac_framer_if.sv
// Byte-stream handshake between the TX datapath (master) and the MAC framer (slave).
// Valid/ready: a byte transfers on a rising clk edge where s_valid_i and s_ready_o are both
// high; the master holds s_data_i/s_last_i stable while s_valid_i is high and not yet accepted;
// s_last_i is only meaningful when s_valid_i is high.
interface tx_mac_framer_if;
  logic [7:0] s_data_i;
  logic       s_valid_i;
  logic       s_last_i;
  logic       s_ready_o;

  modport master (output s_data_i, output s_valid_i, output s_last_i, input s_ready_o);
  modport slave  (input s_data_i, input s_valid_i, input s_last_i, output s_ready_o);
endinterface

// File: rtl/tx_mac_framer.sv
// Transmit MAC framer: preamble + SFD, frame bytes, optional zero pad, CRC-32 FCS, inter-frame gap.
// Optional feature macro: TX_MAC_PAD_EN (adds the PAD state and saturating byte counter so short
// frames are zero-padded to MIN_FRAME_BYTES). Without it, short frames go out unpadded.
// state_o exposes the FSM state for debug/checkers.
module tx_mac_framer #(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  tx_mac_framer_if.slave         s,
  output logic [7:0]             gmii_txd_o,
  output logic                   gmii_tx_en_o,
  output logic                   gmii_tx_er_o,
  output logic                   busy_o,
  output logic                   underrun_o,
  output logic [2:0]             state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DATA = 3'd2,
    S_FCS  = 3'd3,
    S_IFG  = 3'd4
`ifdef TX_MAC_PAD_EN
    , S_PAD = 3'd5
`endif
  } state_t;

  localparam int PW = $clog2(PREAMBLE_BYTES + 1);
  localparam int IW = $clog2(IFG_BYTES + 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_BYTES);
  localparam logic [IW-1:0] IFG_FULL = IW'(IFG_BYTES);
  // IFG state lasts IFG_BYTES-1 cycles; the IDLE cycle that recognises s_valid_i is the last gap byte.
  localparam logic [IW-1:0] IFG_EXIT = IW'(IFG_BYTES - 2);

  if (PREAMBLE_BYTES < 1 || IFG_BYTES < 2 || MIN_FRAME_BYTES < 1) begin : g_bad_params
    $error("tx_mac_framer: unsupported parameter values");
  end

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_cnt_q;
  logic [1:0]      fcs_idx_q;
  logic [IW-1:0]   ifg_cnt_q;
  logic [31:0]     crc_q, crc_next, crc_inv;
  logic            err_q;

  logic [7:0]      txd_d;
  logic            en_d, er_d, und_d, crc_en;
  logic [7:0]      crc_in;

`ifdef TX_MAC_PAD_EN
  localparam int BW = $clog2(MIN_FRAME_BYTES + 1);
  localparam logic [BW-1:0] MIN_CNT = BW'(MIN_FRAME_BYTES);
  logic [BW-1:0] byte_cnt_q, byte_cnt_inc;

  // Saturating frame byte count including the byte handled this cycle.
  always_comb byte_cnt_inc = (byte_cnt_q == MIN_CNT) ? byte_cnt_q : byte_cnt_q + BW'(1);
`endif

  // Reflected CRC-32 (poly 0xEDB88320), one byte per cycle.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_next    = crc32_byte(crc_q, crc_in);
  assign crc_inv     = ~crc_q;
  assign s.s_ready_o = (state_q == S_DATA);
  assign busy_o      = (state_q != S_IDLE);
  assign state_o     = state_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (s.s_valid_i) state_d = S_PRE;
      S_PRE:  if (pre_cnt_q == PRE_LAST) state_d = S_DATA;
      S_DATA: begin
        if (s.s_valid_i && s.s_last_i) begin
`ifdef TX_MAC_PAD_EN
          state_d = (byte_cnt_inc < MIN_CNT) ? S_PAD : S_FCS;
`else
          state_d = S_FCS;
`endif
        end
      end
`ifdef TX_MAC_PAD_EN
      S_PAD:  if (byte_cnt_inc == MIN_CNT) state_d = S_FCS;
`endif
      S_FCS:  if (fcs_idx_q == 2'd3) state_d = S_IFG;
      S_IFG:  if (ifg_cnt_q == IFG_EXIT) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: next values of the registered GMII outputs and CRC input selection.
  always_comb begin
    txd_d  = 8'h00;
    en_d   = 1'b0;
    er_d   = 1'b0;
    und_d  = 1'b0;
    crc_en = 1'b0;
    crc_in = 8'h00;
    unique case (state_q)
      S_PRE: begin
        en_d  = 1'b1;
        txd_d = (pre_cnt_q == PRE_LAST) ? 8'hD5 : 8'h55;
      end
      S_DATA: begin
        en_d = 1'b1;
        if (s.s_valid_i) begin
          txd_d  = s.s_data_i;
          er_d   = err_q;
          crc_en = 1'b1;
          crc_in = s.s_data_i;
        end else begin
          // Underrun: filler byte flagged as error, excluded from the CRC.
          er_d  = 1'b1;
          und_d = ~err_q;
        end
      end
`ifdef TX_MAC_PAD_EN
      S_PAD: begin
        en_d   = 1'b1;
        er_d   = err_q;
        crc_en = 1'b1;
      end
`endif
      S_FCS: begin
        en_d  = 1'b1;
        er_d  = err_q;
        txd_d = crc_inv[{fcs_idx_q, 3'b000} +: 8];
      end
      default: ;
    endcase
  end

  // Registered GMII outputs plus counters, CRC and the sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gmii_txd_o   <= 8'h00;
      gmii_tx_en_o <= 1'b0;
      gmii_tx_er_o <= 1'b0;
      underrun_o   <= 1'b0;
      pre_cnt_q    <= '0;
      fcs_idx_q    <= 2'd0;
      ifg_cnt_q    <= IFG_FULL;
      crc_q        <= 32'hFFFFFFFF;
      err_q        <= 1'b0;
`ifdef TX_MAC_PAD_EN
      byte_cnt_q   <= '0;
`endif
    end else begin
      gmii_txd_o   <= txd_d;
      gmii_tx_en_o <= en_d;
      gmii_tx_er_o <= er_d;
      underrun_o   <= und_d;
      if (crc_en) crc_q <= crc_next;
      unique case (state_q)
        S_IDLE: begin
          pre_cnt_q <= '0;
          fcs_idx_q <= 2'd0;
          err_q     <= 1'b0;
          if (ifg_cnt_q != IFG_FULL) ifg_cnt_q <= ifg_cnt_q + IW'(1);
`ifdef TX_MAC_PAD_EN
          byte_cnt_q <= '0;
`endif
        end
        S_PRE: begin
          pre_cnt_q <= pre_cnt_q + PW'(1);
          crc_q     <= 32'hFFFFFFFF;
        end
        S_DATA: begin
          if (!s.s_valid_i) err_q <= 1'b1;
`ifdef TX_MAC_PAD_EN
          if (s.s_valid_i) byte_cnt_q <= byte_cnt_inc;
`endif
        end
`ifdef TX_MAC_PAD_EN
        S_PAD: byte_cnt_q <= byte_cnt_inc;
`endif
        S_FCS: begin
          fcs_idx_q <= fcs_idx_q + 2'd1;
          if (fcs_idx_q == 2'd3) ifg_cnt_q <= '0;
        end
        S_IFG: ifg_cnt_q <= ifg_cnt_q + IW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_mac_framer.sv
// Bench for tx_mac_framer: reset check, table of directed frames, back-to-back gap,
// mid-FCS reset, and randomized frames against a frame-level reference model.
module tb_tx_mac_framer;

`ifdef TX_MAC_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] gmii_txd;
  logic       gmii_tx_en, gmii_tx_er, busy, underrun;
  logic [2:0] state_dbg;

  tx_mac_framer_if bus ();

  tx_mac_framer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s            (bus),
    .gmii_txd_o   (gmii_txd),
    .gmii_tx_en_o (gmii_tx_en),
    .gmii_tx_er_o (gmii_tx_er),
    .busy_o       (busy),
    .underrun_o   (underrun),
    .state_o      (state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #4 clk = ~clk;

  int n_pass, n_total;

  logic [7:0] pay[$];
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         und_cnt;
  int         gap_cnt;
  int         last_gap;
  bit         in_frame;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: collects {tx_er, txd} for every tx_en cycle, counts underrun pulses and gaps.
  initial begin
    und_cnt = 0; gap_cnt = 0; last_gap = 0; in_frame = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0;
        gap_cnt  = 0;
      end else begin
        if (gmii_tx_en) begin
          got_q.push_back({gmii_tx_er, gmii_txd});
          if (!in_frame) last_gap = gap_cnt;
          in_frame = 1;
          gap_cnt  = 0;
        end else begin
          in_frame = 0;
          gap_cnt++;
        end
        if (underrun) und_cnt++;
      end
    end
  end

  // Reference CRC-32: bit-serial, LSB first, reflected polynomial.
  function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ d[i]) r = (r >> 1) ^ 32'hEDB88320;
      else             r = r >> 1;
    end
    return r;
  endfunction

  // Reference frame: appends the expected wire bytes {er, txd} of one frame to exp_q.
  task automatic build_exp(input int len, input int sa, input int sl, output logic [31:0] fcs);
    logic [31:0] c;
    bit          err;
    int          n;
    c = 32'hFFFFFFFF;
    err = 0;
    repeat (7) exp_q.push_back({1'b0, 8'h55});
    exp_q.push_back({1'b0, 8'hD5});
    for (int i = 0; i < len; i++) begin
      if (sl > 0 && i == sa) begin
        repeat (sl) exp_q.push_back({1'b1, 8'h00});
        err = 1;
      end
      exp_q.push_back({err, pay[i]});
      c = crc_model(c, pay[i]);
    end
    n = len;
    if (PAD_ON) begin
      while (n < 60) begin
        exp_q.push_back({err, 8'h00});
        c = crc_model(c, 8'h00);
        n++;
      end
    end
    fcs = ~c;
    for (int b = 0; b < 4; b++) exp_q.push_back({err, fcs[8*b +: 8]});
  endtask

  // Driver: presents pay[0..len-1]; optionally withholds valid for sl cycles after sa bytes.
  task automatic send_frame(input int len, input int sa, input int sl);
    int idx, guard;
    bit acc, stalled;
    idx = 0; guard = 0; stalled = 0;
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = pay[0];
    bus.s_last_i  = (len == 1);
    while (idx < len && guard < 2000) begin
      @(negedge clk);
      acc = bus.s_valid_i && bus.s_ready_o;
      @(posedge clk);
      #1;
      guard++;
      if (acc) begin
        idx++;
        if (sl > 0 && idx == sa && !stalled) begin
          stalled = 1;
          bus.s_valid_i = 1'b0;
          bus.s_last_i  = 1'b0;
          repeat (sl) @(posedge clk);
          #1;
        end
        if (idx < len) begin
          bus.s_valid_i = 1'b1;
          bus.s_data_i  = pay[idx];
          bus.s_last_i  = (idx == len - 1);
        end else begin
          bus.s_valid_i = 1'b0;
          bus.s_last_i  = 1'b0;
        end
      end
    end
    if (guard >= 2000) check("send_timeout", 32'(guard), 32'(len));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while ((busy || gmii_tx_en) && k < 400);
    if (k >= 400) check("idle_timeout", 32'(busy), 32'd0);
    #1;
  endtask

  task automatic compare_frame(input string tag);
    int m, k, idx;
    logic [8:0] g, e;
    check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    k = 0;
    while (k < m && got_q[k] === exp_q[k]) k++;
    idx = (k == m) ? m - 1 : k;
    if (idx < 0) idx = 0;
    g = (got_q.size() > 0) ? got_q[idx] : 9'h1FF;
    e = exp_q[idx];
    check($sformatf("%s_byte%0d", tag, idx), 32'(g), 32'(e));
  endtask

  function automatic logic [31:0] got_fcs();
    int n;
    n = got_q.size();
    if (n < 4) return 32'h0;
    return {got_q[n-1][7:0], got_q[n-2][7:0], got_q[n-3][7:0], got_q[n-4][7:0]};
  endfunction

  function automatic int count_er();
    int c;
    c = 0;
    foreach (got_q[i]) if (got_q[i][8]) c++;
    return c;
  endfunction

  typedef struct {
    int len;
    int stall_at;
    int stall_len;
    int exp_en;
    int exp_er;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [31:0] fcs;
    int          k, len, sa, sl;
    n_pass = 0; n_total = 0;

    vecs[0] = '{9,  0,  0, PAD_ON ? 72 : 21, 0};
    vecs[1] = '{14, 0,  0, PAD_ON ? 72 : 26, 0};
    vecs[2] = '{64, 20, 3, 79, 51};
    vecs[3] = '{1,  0,  0, PAD_ON ? 72 : 13, 0};
    vecs[4] = '{59, 0,  0, PAD_ON ? 72 : 71, 0};
    vecs[5] = '{60, 0,  0, 72, 0};

    // Reset
    rst_n = 1'b0;
    bus.s_valid_i = 1'b0; bus.s_last_i = 1'b0; bus.s_data_i = 8'h00;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          32'({gmii_txd, gmii_tx_en, gmii_tx_er, busy, underrun, bus.s_ready_o}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;

    // Directed table, payload bytes 0x31, 0x32, ... ("123456789" for the first row)
    for (int v = 0; v < 6; v++) begin
      pay.delete(); exp_q.delete(); got_q.delete(); und_cnt = 0;
      for (int i = 0; i < vecs[v].len; i++) pay.push_back(8'(8'h31 + i));
      build_exp(vecs[v].len, vecs[v].stall_at, vecs[v].stall_len, fcs);
      send_frame(vecs[v].len, vecs[v].stall_at, vecs[v].stall_len);
      wait_idle();
      compare_frame($sformatf("v%0d", v));
      check($sformatf("v%0d_en_cycles", v), 32'(got_q.size()), 32'(vecs[v].exp_en));
      check($sformatf("v%0d_er_cycles", v), 32'(count_er()), 32'(vecs[v].exp_er));
      check($sformatf("v%0d_underrun", v), 32'(und_cnt), (vecs[v].stall_len > 0) ? 32'd1 : 32'd0);
      if (v == 0) check("v0_fcs", got_fcs(), PAD_ON ? fcs : 32'hCBF43926);
    end

    // Back-to-back 64-byte frames with valid held high
    pay.delete(); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 64; i++) pay.push_back(8'($urandom_range(0, 255)));
    build_exp(64, 0, 0, fcs);
    build_exp(64, 0, 0, fcs);
    send_frame(64, 0, 0);
    send_frame(64, 0, 0);
    wait_idle();
    compare_frame("b2b");
    check("b2b_gap", 32'(last_gap), 32'd12);

    // Reset during the third FCS byte, then a clean frame
    pay.delete(); exp_q.delete(); got_q.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'($urandom_range(0, 255)));
    send_frame(20, 0, 0);
    k = 0;
    while (got_q.size() < 8 + 20 + 3 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (k >= 200) check("fcs_wait_timeout", 32'(got_q.size()), 32'd31);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx_en", 32'(gmii_tx_en), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pay.delete(); exp_q.delete(); got_q.delete(); und_cnt = 0;
    for (int i = 0; i < 25; i++) pay.push_back(8'($urandom_range(0, 255)));
    build_exp(25, 0, 0, fcs);
    send_frame(25, 0, 0);
    wait_idle();
    compare_frame("post_rst");
    check("post_rst_fcs", got_fcs(), fcs);

    // Randomized frames with optional underruns
    for (int r = 0; r < 8; r++) begin
      pay.delete(); exp_q.delete(); got_q.delete(); und_cnt = 0;
      len = $urandom_range(1, 70);
      sa = 0; sl = 0;
      if (len > 1 && $urandom_range(0, 1) == 1) begin
        sa = $urandom_range(1, len - 1);
        sl = $urandom_range(1, 4);
      end
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom_range(0, 255)));
      build_exp(len, sa, sl, fcs);
      send_frame(len, sa, sl);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      wait_idle();
      compare_frame($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_fcs", r), got_fcs(), fcs);
      check($sformatf("rnd%0d_underrun", r), 32'(und_cnt), (sl > 0) ? 32'd1 : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
